// File: rtl/timer_arbiter_pkg.sv
// Shared definitions for the timer arbiter: FSM state encoding, interval codes
// used by both the arbiter and the time-parameter store, and default widths.
package timer_arbiter_pkg;

    localparam int SEL_W_DEF   = 2;
    localparam int VALUE_W_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_START  = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef enum logic [SEL_W_DEF-1:0] {
        IV_BASE     = 2'd0,
        IV_EXTENDED = 2'd1,
        IV_YELLOW   = 2'd2,
        IV_WALK     = 2'd3
    } interval_t;

endpackage

// File: rtl/timer_arbiter_rr_pick2.sv
// Two-input round-robin picker, purely combinational.
// On a tie the port not served last wins; last=1 means port 1 was served last.
module rr_pick2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
            gnt = last ? 2'b01 : 2'b10;
        end else if (req0) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Shares one countdown timer between two requesters: grant, look up duration,
// start timer, wait for expiry, pulse done. All outputs registered.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEF,
    parameter int VALUE_W = VALUE_W_DEF
) (
    input  logic               clk,
    input  logic               g_reset,
    input  logic               req0,
    input  logic               req1,
    input  logic [SEL_W-1:0]   sel0,
    input  logic [SEL_W-1:0]   sel1,
    output logic               done0,
    output logic               done1,
    input  logic               abort,
    output logic [SEL_W-1:0]   interval,
    input  logic [VALUE_W-1:0] value,
    output logic               start_timer,
    input  logic               expired,
    output logic               busy,
    output logic [1:0]         grant
);

    state_t             r_state;
    logic [1:0]         r_grant;
    logic [SEL_W-1:0]   r_interval;
    logic               r_last;
    logic               r_done0;
    logic               r_done1;
    logic               r_start;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [1:0]         w_grant_nxt;
    logic [SEL_W-1:0]   w_interval_nxt;
    logic               w_last_nxt;
    logic               w_done0_nxt;
    logic               w_done1_nxt;
    logic               w_start_nxt;
    logic [1:0]         w_pick;
    logic               w_req_g;

    rr_pick2 u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (r_last),
        .gnt  (w_pick)
    );

    assign w_req_g = (r_grant[0] & req0) | (r_grant[1] & req1);

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_interval_nxt = r_interval;
        w_last_nxt     = r_last;
        w_done0_nxt    = 1'b0;
        w_done1_nxt    = 1'b0;
        w_start_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!abort && (req0 || req1)) begin
                    w_state_nxt    = ST_LOOKUP;
                    w_grant_nxt    = w_pick;
                    w_interval_nxt = w_pick[0] ? sel0 : sel1;
                    w_last_nxt     = w_pick[1];
                end
            end
            ST_LOOKUP, ST_START, ST_RUN: begin
                // Abort and withdrawal both outrank expiry; pointer is left as set at grant.
                if (abort || !w_req_g) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 2'b00;
                end else if (r_state == ST_LOOKUP) begin
                    w_state_nxt = ST_START;
                    w_start_nxt = (value != '0);
                end else if (r_state == ST_START) begin
                    if (value == '0) begin
                        w_state_nxt = ST_DONE;
                        w_done0_nxt = r_grant[0];
                        w_done1_nxt = r_grant[1];
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else if (expired) begin
                    w_state_nxt = ST_DONE;
                    w_done0_nxt = r_grant[0];
                    w_done1_nxt = r_grant[1];
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 2'b00;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge g_reset) begin
        if (g_reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= 2'b00;
            r_interval <= '0;
            r_last     <= 1'b1;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_interval <= w_interval_nxt;
            r_last     <= w_last_nxt;
            r_done0    <= w_done0_nxt;
            r_done1    <= w_done1_nxt;
            r_start    <= w_start_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign grant       = r_grant;
    assign interval    = r_interval;
    assign done0       = r_done0;
    assign done1       = r_done1;
    assign start_timer = r_start;
    assign busy        = r_busy;

endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Shares the single countdown timer between two timing requesters: the main traffic-light FSM (port 0) and a walk-lamp sequencer (port 1). Each requester asks for an interval by its time-parameter code. The arbiter picks one requester, looks the duration up in the time-parameter store, starts the timer, waits for expiry and returns a one-cycle done pulse. It sits between the requesters and the timer/time-parameter pair, and it takes the synchronized reprogram signal as an abort.

## Interface
- SEL_W, 2: width of interval code
- VALUE_W, 4: width of duration value (seconds)
- clk  in  1  system clock
- g_reset  in  1  asynchronous, active-high reset
- req0, req1  in  1 each  level request; held until done or withdrawn
- sel0, sel1  in  SEL_W each  interval code; sampled at grant
- done0, done1  out  1 each  one-cycle pulse when that requester's interval has elapsed
- abort  in  1  synchronized reprogram; cancels service
- interval  out  SEL_W  code driven to time-parameter store
- value  in  VALUE_W  duration from store, valid one cycle after interval changes
- start_timer  out  1  one-cycle pulse that loads and starts the timer
- expired  in  1  timer expiry flag
- busy  out  1  high in every state except IDLE
- grant  out  2  one-hot owner; 00 when idle

## Operation
- States: IDLE, LOOKUP, START, RUN, DONE.
- IDLE → LOOKUP when any req is high.
  - Winner chosen by round-robin: with both requesting, grant the port not served last.
  - The last-served pointer resets to 1, so port 0 wins the first tie.
  - The winner's sel is latched into interval. grant is set and the pointer is updated.
- LOOKUP → START after 1 cycle. The store output settles during this cycle.
- START:
  - If value == 0: assert no start_timer and go directly to DONE.
  - Otherwise pulse start_timer for 1 cycle and go to RUN.
- RUN → DONE when expired is high.
- DONE: pulse done of the granted port for 1 cycle, clear grant, go to IDLE.
- Withdrawal: if the granted req drops in LOOKUP, START or RUN, go to IDLE next cycle.
  - No done pulse. grant is cleared. The pointer still counts the service.
- abort: high in any state forces IDLE next cycle.
  - No done pulse. grant is cleared. The pointer is unchanged.
  - While abort is held, IDLE grants nothing.
- expired outside RUN is ignored. A non-granted req has no effect until IDLE.
- interval holds its last value in IDLE.
- A requester must drop req the cycle after it sees done. A req still high in the IDLE cycle after DONE is a new request.

## Timing
- Reset values:
  - state IDLE; grant 00; done0/done1 0; start_timer 0; busy 0.
  - interval 0; pointer = port 1 served last.
- All outputs are registered. The asynchronous g_reset forces reset values immediately, mid-operation included.
- Latency, with req high in IDLE at cycle n:
  - n+1 LOOKUP: grant and interval valid.
  - n+2 START: start_timer high.
  - RUN from n+3.
  - done high the cycle after expired is first seen in RUN.
- value == 0: done is high at n+3, and start_timer never pulses.
- Back-to-back with both requesting continuously: the service order alternates 0,1,0,1. There is a 1-cycle IDLE gap between a DONE and the next LOOKUP.
- Simultaneous expired and abort in RUN: abort wins, no done.
- Simultaneous expired and withdrawal in RUN: withdrawal wins, no done.

## Structure
- Shared package:
  - state encoding.
  - interval codes (BASE, EXTENDED, YELLOW, WALK), reused by the time-parameter store and the FSM.
  - SEL_W and VALUE_W defaults.
- Sub-module rr_pick2: combinational two-input round-robin picker. Inputs req0, req1, last; outputs gnt[1:0]. The pointer register stays in timer_arbiter.

## Test plan
- Single request: req0=1, sel0=BASE, store returns 6 → start_timer at n+2; expired driven 6 pulses later; done0 is a 1-cycle pulse; grant returns to 00.
- Tie after reset: req0=req1=1 with sel0=YELLOW, sel1=WALK → port 0 served first (interval=YELLOW), then port 1 (interval=WALK); the next tie goes to port 0.
- Zero duration: sel1 maps to value 0 → done1 at n+3; start_timer stays 0 throughout.
- Abort mid-RUN: abort=1 three cycles into RUN → IDLE next cycle, no done; after abort drops, a held req is re-granted.
- Withdrawal: req0 drops in LOOKUP → IDLE, no done0; a pending req1 is granted on the next IDLE cycle.
- Reset mid-operation: g_reset asserted in RUN, asynchronous to the clock edge → grant=00, busy=0, start_timer=0 immediately; the first tie after release goes to port 0.
